dcache_wb_dm: RTL and testbench



---
 rtl/dcache_wb_dm_pkg.sv | 36 +++
 rtl/dcache_wb_dm_if.sv | 32 +++
 rtl/dcache_wb_dm_line_array.sv | 58 +++++
 rtl/dcache_wb_dm.sv | 112 +++++++++++
 tb/tb_dcache_wb_dm.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_wb_dm_pkg.sv
// Shared types and address helpers for the direct-mapped write-back cache.
// Address layout: {tag, index, word offset[1:0]}.
package cache_pkg;

  localparam int ADDR_W     = 30;
  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 128;
  localparam int MEM_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  function automatic logic [1:0] addr_off(
    input logic [ADDR_W-1:0] a
  );
    return a[1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_idx(
    input logic [ADDR_W-1:0] a,
    input int                idx_w
  );
    return (a >> 2) & ((30'd1 << idx_w) - 30'd1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] a,
    input int                idx_w
  );
    return a >> (2 + idx_w);
  endfunction

endpackage

// File: rtl/dcache_wb_dm_if.sv
// Block-level memory bus between the cache and the next memory level.
// master = cache side, slave = memory side.
interface dcache_wb_dm_if
  import cache_pkg::*;
();

  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [BLOCK_W-1:0]    mem_wdata;
  logic                  mem_ready;
  logic [BLOCK_W-1:0]    mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/dcache_wb_dm_line_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one write
// port doing either a full line fill or a single word update.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 25,
  parameter int LINE_W     = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  input  logic              word_en,
  input  logic [1:0]        word_off,
  input  logic [WORD_W-1:0] word_data
);

  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TAG_W-1:0]      tags [NUM_BLOCKS];
  logic [LINE_W-1:0]     data [NUM_BLOCKS];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_en) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Payload is never cleared; writes are still blocked during reset.
  always_ff @(posedge clk) begin
    if (rst_n && fill_en) begin
      tags[idx] <= fill_tag;
      data[idx] <= fill_data;
    end else if (rst_n && word_en) begin
      data[idx][{word_off, 5'd0} +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped write-back write-allocate cache; stalls the pipeline
// on a miss while it writes back a dirty victim and refills the line.
module dcache_wb_dm
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int IDX_W           = $clog2(NUM_BLOCKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0] proc_wdata,
  output logic              proc_stall,
  output logic [WORD_W-1:0] proc_rdata,
  dcache_wb_dm_if.master    mem
);

  localparam int TAG_W  = ADDR_W - 2 - IDX_W;
  localparam int LINE_W = WORDS_PER_BLOCK * WORD_W;

  state_t state, next;

  logic [TAG_W-1:0]  tag_a;
  logic [IDX_W-1:0]  idx_a;
  logic [1:0]        off_a;
  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              fill_en;
  logic              word_en;
  logic              hit;
  logic              req;

  assign tag_a = TAG_W'(addr_tag(proc_addr, IDX_W));
  assign idx_a = IDX_W'(addr_idx(proc_addr, IDX_W));
  assign off_a = addr_off(proc_addr);
  assign hit   = rd_valid && (rd_tag == tag_a);
  assign req   = proc_read || proc_write;

  cache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W),
    .LINE_W     (LINE_W)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx_a),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_en   (fill_en),
    .fill_tag  (tag_a),
    .fill_data (mem.mem_rdata),
    .word_en   (word_en),
    .word_off  (off_a),
    .word_data (proc_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next          = state;
    proc_stall    = 1'b0;
    proc_rdata    = '0;
    fill_en       = 1'b0;
    word_en       = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (req && hit) begin
          // A read+write pair returns the word as it was before the store.
          if (proc_read)
            proc_rdata = rd_data[{off_a, 5'd0} +: WORD_W];
          word_en = proc_write;
        end else if (req) begin
          proc_stall = 1'b1;
          next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        proc_stall    = 1'b1;
        mem.mem_write = 1'b1;
        mem.mem_addr  = {rd_tag, idx_a};
        mem.mem_wdata = rd_data;
        if (mem.mem_ready) next = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall   = 1'b1;
        mem.mem_read = 1'b1;
        mem.mem_addr = proc_addr[ADDR_W-1:2];
        if (mem.mem_ready) begin
          fill_en = 1'b1;
          next    = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Directed bench for dcache_wb_dm: cold miss, write hit, dirty and clean
// conflicts, idle with stray mem_ready, read+write, reset mid-refill.
module tb_dcache_wb_dm;
  import cache_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              proc_read;
  logic              proc_write;
  logic [ADDR_W-1:0] proc_addr;
  logic [WORD_W-1:0] proc_wdata;
  logic              proc_stall;
  logic [WORD_W-1:0] proc_rdata;

  int checks;
  int errors;

  dcache_wb_dm_if mif ();

  dcache_wb_dm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem        (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %0b want 0", proc_stall);
    end
    checks++;
    if ({mif.mem_read, mif.mem_write} !== 2'b00) begin
      errors++;
      $display("FAIL reset_rw got %b want 00",
               {mif.mem_read, mif.mem_write});
    end
    checks++;
    if (mif.mem_addr !== 28'h0 || mif.mem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h want 0/0",
               mif.mem_addr, mif.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_read();
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h5;
    #1;
    checks++;
    if (proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL cold_stall0 got %0b want 1", proc_stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (proc_stall !== 1'b1 || mif.mem_read !== 1'b1 ||
        mif.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL cold_alloc got s%0b r%0b w%0b want s1 r1 w0",
               proc_stall, mif.mem_read, mif.mem_write);
    end
    checks++;
    if (mif.mem_addr !== 28'h1) begin
      errors++;
      $display("FAIL cold_addr got %h want 0000001", mif.mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    mif.mem_ready = 1'b1;
    mif.mem_rdata = {32'h44, 32'h33, 32'hDEAD_BEEF, 32'h11};
    @(negedge clk);
    mif.mem_ready = 1'b0;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cold_hit got s%0b %h want s0 deadbeef",
               proc_stall, proc_rdata);
    end
    proc_addr = 30'h4;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h11) begin
      errors++;
      $display("FAIL cold_word0 got s%0b %h want s0 00000011",
               proc_stall, proc_rdata);
    end
  endtask

  task automatic test_write_hit();
    @(negedge clk);
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h5;
    proc_wdata = 32'h1234_5678;
    #1;
    checks++;
    if (proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL whit_stall got %0b want 0", proc_stall);
    end
    @(negedge clk);
    proc_write = 1'b0;
    proc_read  = 1'b1;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL whit_read got s%0b %h want s0 12345678",
               proc_stall, proc_rdata);
    end
    checks++;
    if ({mif.mem_read, mif.mem_write} !== 2'b00) begin
      errors++;
      $display("FAIL whit_mem got %b want 00",
               {mif.mem_read, mif.mem_write});
    end
  endtask

  task automatic test_dirty_conflict();
    @(negedge clk);
    proc_addr = 30'h105;
    #1;
    checks++;
    if (proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL dirty_stall got %0b want 1", proc_stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mif.mem_write !== 1'b1 || mif.mem_read !== 1'b0 ||
        mif.mem_addr !== 28'h1) begin
      errors++;
      $display("FAIL dirty_wb got w%0b r%0b %h want w1 r0 0000001",
               mif.mem_write, mif.mem_read, mif.mem_addr);
    end
    checks++;
    if (mif.mem_wdata[63:32] !== 32'h1234_5678 ||
        mif.mem_wdata[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL dirty_wdata got %h want ..12345678_00000011",
               mif.mem_wdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mif.mem_write !== 1'b1 ||
        mif.mem_wdata[63:32] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL dirty_hold got w%0b %h want w1 12345678",
               mif.mem_write, mif.mem_wdata[63:32]);
    end
    mif.mem_ready = 1'b1;
    mif.mem_rdata = {32'h0, 32'h0, 32'hCAFE_0001, 32'h0};
    @(negedge clk);
    mif.mem_ready = 1'b0;
    #1;
    checks++;
    if (mif.mem_read !== 1'b1 || mif.mem_write !== 1'b0 ||
        mif.mem_addr !== 28'h41 || proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL dirty_alloc got r%0b w%0b %h s%0b want r1 w0 41 s1",
               mif.mem_read, mif.mem_write, mif.mem_addr, proc_stall);
    end
    @(negedge clk);
    mif.mem_ready = 1'b1;
    @(negedge clk);
    mif.mem_ready = 1'b0;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL dirty_hit got s%0b %h want s0 cafe0001",
               proc_stall, proc_rdata);
    end
  endtask

  task automatic test_clean_conflict();
    @(negedge clk);
    proc_addr = 30'h205;
    #1;
    checks++;
    if (proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL clean_stall got %0b want 1", proc_stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mif.mem_write !== 1'b0 || mif.mem_read !== 1'b1 ||
        mif.mem_addr !== 28'h81) begin
      errors++;
      $display("FAIL clean_alloc got w%0b r%0b %h want w0 r1 81",
               mif.mem_write, mif.mem_read, mif.mem_addr);
    end
    mif.mem_ready = 1'b1;
    mif.mem_rdata = {32'h0, 32'h0, 32'hBEEF_0002, 32'h0};
    @(negedge clk);
    mif.mem_ready = 1'b0;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'hBEEF_0002) begin
      errors++;
      $display("FAIL clean_hit got s%0b %h want s0 beef0002",
               proc_stall, proc_rdata);
    end
  endtask

  task automatic test_idle();
    @(negedge clk);
    proc_read  = 1'b0;
    proc_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mif.mem_ready = (i == 4);
      #1;
      checks++;
      if ({proc_stall, mif.mem_read, mif.mem_write} !== 3'b000) begin
        errors++;
        $display("FAIL idle_%0d got %b want 000", i,
                 {proc_stall, mif.mem_read, mif.mem_write});
      end
    end
    @(negedge clk);
    mif.mem_ready = 1'b0;
    proc_read = 1'b1;
    proc_addr = 30'h205;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'hBEEF_0002) begin
      errors++;
      $display("FAIL idle_reread got s%0b %h want s0 beef0002",
               proc_stall, proc_rdata);
    end
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    proc_read  = 1'b1;
    proc_write = 1'b1;
    proc_addr  = 30'h205;
    proc_wdata = 32'h55AA_55AA;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'hBEEF_0002) begin
      errors++;
      $display("FAIL rw_pre got s%0b %h want s0 beef0002",
               proc_stall, proc_rdata);
    end
    @(negedge clk);
    proc_write = 1'b0;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL rw_post got s%0b %h want s0 55aa55aa",
               proc_stall, proc_rdata);
    end
  endtask

  task automatic test_reset_mid_alloc();
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h9;
    @(negedge clk);
    #1;
    checks++;
    if (mif.mem_read !== 1'b1 || mif.mem_addr !== 28'h2) begin
      errors++;
      $display("FAIL rst_alloc got r%0b %h want r1 0000002",
               mif.mem_read, mif.mem_addr);
    end
    rst_n = 1'b0;
    mif.mem_ready = 1'b1;
    mif.mem_rdata = {32'h0, 32'h0, 32'h77, 32'h0};
    @(negedge clk);
    rst_n = 1'b1;
    mif.mem_ready = 1'b0;
    proc_read = 1'b0;
    #1;
    checks++;
    if (mif.mem_read !== 1'b0 || proc_stall !== 1'b0 ||
        mif.mem_addr !== 28'h0) begin
      errors++;
      $display("FAIL rst_drop got r%0b s%0b %h want r0 s0 0",
               mif.mem_read, proc_stall, mif.mem_addr);
    end
    proc_read = 1'b1;
    #1;
    checks++;
    if (proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_remiss got %0b want 1", proc_stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mif.mem_read !== 1'b1 || mif.mem_write !== 1'b0 ||
        mif.mem_addr !== 28'h2) begin
      errors++;
      $display("FAIL rst_realloc got r%0b w%0b %h want r1 w0 2",
               mif.mem_read, mif.mem_write, mif.mem_addr);
    end
    mif.mem_ready = 1'b1;
    mif.mem_rdata = {32'h0, 32'h0, 32'h99, 32'h0};
    @(negedge clk);
    mif.mem_ready = 1'b0;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h99) begin
      errors++;
      $display("FAIL rst_hit got s%0b %h want s0 00000099",
               proc_stall, proc_rdata);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    proc_read     = 1'b0;
    proc_write    = 1'b0;
    proc_addr     = '0;
    proc_wdata    = '0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_conflict();
    test_clean_conflict();
    test_idle();
    test_rw_both();
    test_reset_mid_alloc();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
